// File: rtl/ram_mp_be.sv
// Multi-port byte-masked RAM: lowest-index port wins per-lane write collisions, optional zero fill after reset.
// Read latency 1 cycle (2 with OUTREG); no backpressure, requests are simply ignored while ready is low.
module ram_mp_be #(
    parameter  int DATA     = 32,
    parameter  int BYTE     = 8,
    parameter  int DEPTH    = 16,
    parameter  int PORT     = 2,
    parameter  int OUTREG   = 0,
    parameter  int INIT_CLR = 1,
    localparam int LANE     = DATA / BYTE,
    localparam int ADDR     = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset_,
    output logic                       ready,
    input  logic [PORT-1:0]            en,
    input  logic [PORT-1:0]            rw_,
    input  logic [PORT-1:0][ADDR-1:0]  addr,
    input  logic [PORT-1:0][LANE-1:0]  wmask,
    input  logic [PORT-1:0][DATA-1:0]  wdata,
    output logic [PORT-1:0][DATA-1:0]  rdata,
    output logic [PORT-1:0]            rvalid,
    output logic [PORT-1:0]            conflict
);

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR-1:0]         cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic                    clr_we;

    logic [DATA-1:0]         mem [DEPTH];

    logic [PORT-1:0]         in_rng, rd_go, wr_go;
    logic [PORT-1:0][DATA-1:0] rd_dat_q, rd_dat_d;
    logic [PORT-1:0]         rd_vld_q, rd_vld_d;
    logic [PORT-1:0]         conflict_q, conflict_d;

    // Clear sequencer; ready is registered from the state so it never glitches
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            INIT: begin
                if (INIT_CLR != 0) begin
                    clr_we = 1'b1;
                    if (cnt_q == ADDR'(DEPTH - 1)) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + ADDR'(1);
                    end
                end else begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
        ready_d = (INIT_CLR != 0) ? (state_q == RUN) : (state_d == RUN);
    end

    always_comb begin
        in_rng = '0;
        rd_go  = '0;
        wr_go  = '0;
        for (int p = 0; p < PORT; p++) begin
            in_rng[p] = {1'b0, addr[p]} < (ADDR + 1)'(DEPTH);
            rd_go[p]  = ready_q & en[p] & rw_[p];
            wr_go[p]  = ready_q & en[p] & ~rw_[p] & in_rng[p];
        end
    end

    // Ports applied highest-first so the lowest-index port's lane is the last assignment
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt_q] <= '0;
        end
        for (int p = PORT - 1; p >= 0; p--) begin
            if (wr_go[p]) begin
                for (int k = 0; k < LANE; k++) begin
                    if (wmask[p][k]) begin
                        mem[addr[p]][k*BYTE +: BYTE] <= wdata[p][k*BYTE +: BYTE];
                    end
                end
            end
        end
    end

    // Read samples the array before this edge's writes land, giving read-first behaviour
    always_comb begin
        rd_dat_d = rd_dat_q;
        rd_vld_d = '0;
        for (int p = 0; p < PORT; p++) begin
            if (rd_go[p]) begin
                rd_vld_d[p] = 1'b1;
                rd_dat_d[p] = in_rng[p] ? mem[addr[p]] : '0;
            end
        end
    end

    always_comb begin
        conflict_d = '0;
        for (int p = 1; p < PORT; p++) begin
            for (int q = 0; q < p; q++) begin
                if (wr_go[p] && wr_go[q] && (addr[p] == addr[q]) && |(wmask[p] & wmask[q])) begin
                    conflict_d[p] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            rd_dat_q   <= '0;
            rd_vld_q   <= '0;
            conflict_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            rd_dat_q   <= rd_dat_d;
            rd_vld_q   <= rd_vld_d;
            conflict_q <= conflict_d;
        end
    end

    generate
        if (OUTREG != 0) begin : g_oreg
            logic [PORT-1:0][DATA-1:0] out_dat_q, out_dat_d;
            logic [PORT-1:0]           out_vld_q, out_vld_d;

            always_comb begin
                out_dat_d = out_dat_q;
                out_vld_d = rd_vld_q;
                for (int p = 0; p < PORT; p++) begin
                    if (rd_vld_q[p]) begin
                        out_dat_d[p] = rd_dat_q[p];
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_) begin
                if (!reset_) begin
                    out_dat_q <= '0;
                    out_vld_q <= '0;
                end else begin
                    out_dat_q <= out_dat_d;
                    out_vld_q <= out_vld_d;
                end
            end

            assign rdata  = out_dat_q;
            assign rvalid = out_vld_q;
        end else begin : g_noreg
            assign rdata  = rd_dat_q;
            assign rvalid = rd_vld_q;
        end
    endgenerate

    assign ready    = ready_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_ram_mp_be.sv
// Directed bench for ram_mp_be: three instances (plain, output-registered, DEPTH=12) share one stimulus stream.
module tb_ram_mp_be;

    logic                 clk;
    logic                 reset_;
    logic [1:0]           en;
    logic [1:0]           rw_;
    logic [1:0][3:0]      addr;
    logic [1:0][3:0]      wmask;
    logic [1:0][31:0]     wdata;

    logic                 ready0, ready1, ready2;
    logic [1:0][31:0]     rdata0, rdata1, rdata2;
    logic [1:0]           rvalid0, rvalid1, rvalid2;
    logic [1:0]           conflict0, conflict1, conflict2;

    int n_asrt = 0;
    int n_fail = 0;

    logic [31:0] exp_mem [12];

    ram_mp_be u0 (
        .clk(clk), .reset_(reset_), .ready(ready0), .en(en), .rw_(rw_), .addr(addr),
        .wmask(wmask), .wdata(wdata), .rdata(rdata0), .rvalid(rvalid0), .conflict(conflict0)
    );

    ram_mp_be #(.OUTREG(1)) u1 (
        .clk(clk), .reset_(reset_), .ready(ready1), .en(en), .rw_(rw_), .addr(addr),
        .wmask(wmask), .wdata(wdata), .rdata(rdata1), .rvalid(rvalid1), .conflict(conflict1)
    );

    ram_mp_be #(.DEPTH(12)) u2 (
        .clk(clk), .reset_(reset_), .ready(ready2), .en(en), .rw_(rw_), .addr(addr),
        .wmask(wmask), .wdata(wdata), .rdata(rdata2), .rvalid(rvalid2), .conflict(conflict2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en    = '0;
        rw_   = '0;
        addr  = '0;
        wmask = '0;
        wdata = '0;
    endtask

    task automatic wr0(input logic [3:0] a, input logic [3:0] m, input logic [31:0] d);
        en       = 2'b01;
        rw_      = 2'b00;
        addr[0]  = a;
        wmask[0] = m;
        wdata[0] = d;
    endtask

    initial begin
        reset_ = 1'b0;
        idle();
        tick();
        tick();

        chk("rst_ready0", 32'(ready0), 32'd0);
        chk("rst_ready1", 32'(ready1), 32'd0);
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_conflict0", 32'(conflict0), 32'd0);
        chk("rst_rdata0_p0", rdata0[0], 32'd0);
        chk("rst_rdata1_p1", rdata1[1], 32'd0);

        // Start a sweep, then abort it at clear count 8
        reset_ = 1'b1;
        repeat (8) tick();
        chk("mid_init_ready", 32'(ready0), 32'd0);
        reset_ = 1'b0;
        tick();
        reset_ = 1'b1;

        for (int c = 1; c <= 17; c++) begin
            tick();
            chk($sformatf("ready16_c%0d", c), 32'(ready0), 32'(c >= 17));
            chk($sformatf("ready12_c%0d", c), 32'(ready2), 32'(c >= 13));
        end
        chk("ready_oreg", 32'(ready1), 32'd1);

        // All 16 words read back as zero, both ports back-to-back
        for (int i = 0; i < 16; i++) begin
            en      = 2'b11;
            rw_     = 2'b11;
            addr[0] = 4'(i);
            addr[1] = 4'(15 - i);
            tick();
            chk($sformatf("clr_p0_a%0d", i), rdata0[0], 32'd0);
            chk($sformatf("clr_p1_a%0d", 15 - i), rdata0[1], 32'd0);
            chk($sformatf("clr_rvalid_%0d", i), 32'(rvalid0), 32'd3);
            chk($sformatf("clr_rvalid_oreg_%0d", i), 32'(rvalid1), (i == 0) ? 32'd0 : 32'd3);
        end
        idle();
        tick();
        chk("rvalid_drop", 32'(rvalid0), 32'd0);
        chk("rvalid_oreg_tail", 32'(rvalid1), 32'd3);
        tick();
        chk("rvalid_oreg_drop", 32'(rvalid1), 32'd0);

        // Write then cross-port read
        wr0(4'd3, 4'b1111, 32'hdeadbeef);
        tick();
        en      = 2'b10;
        rw_     = 2'b10;
        addr[1] = 4'd3;
        tick();
        chk("xport_rdata", rdata0[1], 32'hdeadbeef);
        chk("xport_rvalid", 32'(rvalid0[1]), 32'd1);
        chk("xport_oreg_early", 32'(rvalid1[1]), 32'd0);
        idle();
        tick();
        chk("xport_oreg_rdata", rdata1[1], 32'hdeadbeef);
        chk("xport_oreg_rvalid", 32'(rvalid1[1]), 32'd1);
        chk("xport_rvalid_off", 32'(rvalid0[1]), 32'd0);
        chk("xport_hold", rdata0[1], 32'hdeadbeef);

        // Byte mask merge
        wr0(4'd5, 4'b1111, 32'h11223344);
        tick();
        wr0(4'd5, 4'b0101, 32'haabbccdd);
        tick();
        en      = 2'b01;
        rw_     = 2'b01;
        addr[0] = 4'd5;
        tick();
        chk("bmask", rdata0[0], 32'h11bb33dd);
        idle();
        tick();
        chk("bmask_oreg", rdata1[0], 32'h11bb33dd);

        // Write-write collision on addr 7
        en       = 2'b11;
        rw_      = 2'b00;
        addr[0]  = 4'd7;
        addr[1]  = 4'd7;
        wmask[0] = 4'b0001;
        wmask[1] = 4'b0011;
        wdata[0] = 32'h000000ff;
        wdata[1] = 32'hffffffff;
        tick();
        chk("coll_conflict", 32'(conflict0), 32'd2);
        chk("coll_conflict_oreg", 32'(conflict1), 32'd2);
        chk("coll_conflict_d12", 32'(conflict2), 32'd2);
        idle();
        en      = 2'b01;
        rw_     = 2'b01;
        addr[0] = 4'd7;
        tick();
        chk("coll_pulse_end", 32'(conflict0), 32'd0);
        chk("coll_data", rdata0[0], 32'h0000ffff);

        // Read-first on same-cycle read/write
        wr0(4'd2, 4'b1111, 32'h12345678);
        tick();
        en       = 2'b11;
        rw_      = 2'b10;
        addr[0]  = 4'd2;
        addr[1]  = 4'd2;
        wmask[0] = 4'b1111;
        wdata[0] = 32'hcafef00d;
        tick();
        chk("rw_old", rdata0[1], 32'h12345678);
        chk("rw_noconf", 32'(conflict0), 32'd0);
        idle();
        en      = 2'b10;
        rw_     = 2'b10;
        addr[1] = 4'd2;
        tick();
        chk("rw_new", rdata0[1], 32'hcafef00d);

        // Out of range on the DEPTH=12 instance
        idle();
        en      = 2'b01;
        rw_     = 2'b01;
        addr[0] = 4'd13;
        tick();
        chk("oor_rdata", rdata2[0], 32'd0);
        chk("oor_rvalid", 32'(rvalid2[0]), 32'd1);
        en       = 2'b11;
        rw_      = 2'b00;
        addr[0]  = 4'd13;
        addr[1]  = 4'd13;
        wmask[0] = 4'b1111;
        wmask[1] = 4'b1111;
        wdata[0] = 32'hffffffff;
        wdata[1] = 32'ha5a5a5a5;
        tick();
        chk("oor_noconf", 32'(conflict2), 32'd0);
        chk("inrange13_conf", 32'(conflict0), 32'd2);
        idle();
        en      = 2'b01;
        rw_     = 2'b01;
        addr[0] = 4'd13;
        tick();
        chk("oor_reread", rdata2[0], 32'd0);
        chk("inrange13_data", rdata0[0], 32'hffffffff);

        for (int i = 0; i < 12; i++) exp_mem[i] = 32'd0;
        exp_mem[2] = 32'hcafef00d;
        exp_mem[3] = 32'hdeadbeef;
        exp_mem[5] = 32'h11bb33dd;
        exp_mem[7] = 32'h0000ffff;
        for (int i = 0; i < 12; i++) begin
            en      = 2'b01;
            rw_     = 2'b01;
            addr[0] = 4'(i);
            tick();
            chk($sformatf("d12_word%0d", i), rdata2[0], exp_mem[i]);
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_mp_be.md
# ram_mp_be

Parametrised multi-port synchronous RAM with per-byte write masks, deterministic write-collision resolution, optional output register and a post-reset clear sequencer. It is the general storage macro for register files, small buffers and lookup tables: any number of independent read/write ports share one array, and a ready flag tells clients when the array contents are defined.

## Interface
- DATA, 32, word width in bits; must be a multiple of BYTE
- BYTE, 8, byte-lane width; LANE = DATA/BYTE
- DEPTH, 16, number of words; any value ≥ 2, non-power-of-2 allowed
- PORT, 2, number of independent ports
- OUTREG, 0, 1 adds an output register stage (+1 cycle read latency)
- INIT_CLR, 1, 1 zero-fills the array after every reset
- ADDR, $clog2(DEPTH), address width (derived, not overridden)

- clk  in  1  single clock, all state on rising edge
- reset_  in  1  asynchronous, active-low reset
- ready  out  1  array initialised, requests accepted
- en  in  [PORT]  per-port request enable
- rw_  in  [PORT]  1 = read, 0 = write
- addr  in  [PORT][ADDR]  word address
- wmask  in  [PORT][LANE]  byte-lane write enables
- wdata  in  [PORT][DATA]  write data
- rdata  out  [PORT][DATA]  read data
- rvalid  out  [PORT]  rdata carries the result of a read
- conflict  out  [PORT]  port lost ≥1 byte in a write collision

## Operation
- Sequencer states: INIT, RUN.
- reset_ low: state INIT, clear counter 0, ready 0, rdata/rvalid/conflict all 0, every pipeline stage cleared. Array contents are not touched by reset itself.
- INIT (INIT_CLR=1): one word per cycle, counter 0..DEPTH-1 written with zero; after word DEPTH-1 move to RUN. INIT_CLR=0: INIT lasts one cycle and moves straight to RUN; contents undefined.
- RUN: ready 1; stays until reset_ low.
- Requests with en=1 while ready=0 are ignored: no write, no rvalid.
- Write (en=1, rw_=0): for each lane k with wmask[k]=1, byte k of mem[addr] ← wdata byte k. wmask all-zero is a no-op.
- Read (en=1, rw_=1): rdata ← mem[addr] with rvalid 1 at the required latency. rdata holds its last value when no read is returning; rvalid 0 in those cycles.
- Read vs. write to the same address, same cycle, different ports: read-first; the read returns the pre-write word.
- Write vs. write to the same address, same cycle: resolved per byte lane; the lowest-index port with that lane enabled wins. Each port with a lane overridden by a lower-index port gets conflict=1 one cycle later, otherwise conflict=0 (single-cycle pulse per collision).
- addr ≥ DEPTH: write dropped; read returns 0 with rvalid 1; no conflict.
- reset_ asserted mid-INIT: counter returns to 0; sweep restarts from word 0 after release. Reset mid-read: the pending rvalid is dropped.

## Timing
- reset_ release to ready=1: DEPTH+1 cycles for INIT_CLR=1 (ready rises on the edge after word DEPTH-1 is written); 1 cycle for INIT_CLR=0.
- Read latency: OUTREG=0, rdata/rvalid valid after the first rising edge following the request (1 cycle); OUTREG=1, 2 cycles. Full throughput: one read per port per cycle, back-to-back.
- A write at edge N is visible to any port reading the same address at edge N+1.
- conflict is registered: it asserts 1 cycle after the colliding write, independent of OUTREG.
- The ready transition is glitch-free (registered output).

## Test plan
- INIT_CLR=1, DEPTH=16: release reset_ -> ready stays 0 for 16 cycles and rises at cycle 17; reads of all 16 addresses return 0x00000000 with rvalid.
- Port 0 writes 0xdeadbeef to addr 3 (wmask 4'b1111), then port 1 reads addr 3 -> rdata[1]=0xdeadbeef after 1 cycle (OUTREG=0) or 2 cycles (OUTREG=1), with rvalid[1] aligned.
- Byte mask: addr 5 = 0x11223344; write 0xaabbccdd with wmask 4'b0101 -> read returns 0x11bb33dd.
- Collision: port 0 writes 0x000000ff mask 4'b0001 and port 1 writes 0xffffffff mask 4'b0011 to addr 7, same cycle -> mem[7]=0x0000ffff (lane0 from port 0), conflict=2'b10 next cycle only.
- Same-cycle read and write: port 1 reads addr 2 (holding 0x12345678) while port 0 writes 0xcafef00d there -> rdata[1]=0x12345678, next read returns 0xcafef00d.
- Reset mid-INIT and out-of-range: pulse reset_ low at clear count 8 -> ready rises 17 cycles after release; with DEPTH=12, read addr 13 -> rdata 0, rvalid 1; write addr 13 leaves all words unchanged.
